// File: rtl/onehot_encoder_reg_if.sv
// Handshake bundle for onehot_encoder_reg.
//   Input side : in (IN_W one-hot word), in_valid, in_ready
//   Output side: binary_out (OUT_W index), out_err, out_valid, out_ready
// The slave modport is the encoder's view; master is the view of the
// agent that feeds words in and drains indices out.
interface onehot_encoder_reg_if #(
  parameter int IN_W = 4
);
  localparam int OUT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

  logic [IN_W-1:0]  in;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] binary_out;
  logic             out_err;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in, in_valid, out_ready,
    output in_ready, binary_out, out_err, out_valid
  );

  modport master (
    output in, in_valid, out_ready,
    input  in_ready, binary_out, out_err, out_valid
  );
endinterface

// File: rtl/onehot_encoder_reg.sv
// Registered one-hot to binary encoder with a one-entry skid buffer.
// An IN_W-bit word accepted on the input handshake is encoded to the index
// of its highest set bit plus an error flag (word not exactly one-hot), and
// presented on the output handshake one cycle later. The skid entry keeps
// full throughput under backpressure; in_ready depends only on registered
// occupancy and rst, never on out_ready.
//
// Parameters:
//   IN_W  - input word width, power of 2, >= 2
//   CNT_W - error counter width (only used with ONEHOT_ENC_ERR_COUNT_EN)
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset
//   bus       - onehot_encoder_reg_if.slave (in/in_valid/in_ready,
//               binary_out/out_err/out_valid/out_ready)
//   err_count - saturating count of accepted error words; exists only when
//               ONEHOT_ENC_ERR_COUNT_EN is defined
module onehot_encoder_reg #(
  parameter int IN_W  = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  onehot_encoder_reg_if.slave      bus
`ifdef ONEHOT_ENC_ERR_COUNT_EN
  ,
  output logic [CNT_W-1:0]         err_count
`endif
);
  localparam int OUT_W = $clog2(IN_W);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Later set bits overwrite earlier ones, so the highest set bit wins.
  function automatic logic [OUT_W-1:0] hi_index(input logic [IN_W-1:0] w);
    logic [OUT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (w[i]) idx = OUT_W'(i);
    end
    return idx;
  endfunction

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  function automatic logic is_onehot(input logic [IN_W-1:0] w);
    logic [IN_W-1:0] one;
    one = {{(IN_W-1){1'b0}}, 1'b1};
    return (w != '0) && ((w & (w - one)) == '0);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  state_t           state, state_nxt;
  logic             load_out, load_skid, skid_to_out;
  logic             accept, transfer;

  logic [OUT_W-1:0] enc_idx_p0;
  logic             enc_err_p0;

  logic [OUT_W-1:0] out_idx_p1;
  logic             out_err_p1;
  logic [OUT_W-1:0] skid_idx_p1;
  logic             skid_err_p1;

  // ---- stage p0: combinational encode of the presented word ----
  assign enc_idx_p0 = hi_index(bus.in);
  assign enc_err_p0 = !is_onehot(bus.in);

  assign bus.in_ready   = (state != FULL) && !rst;
  assign bus.out_valid  = (state != EMPTY);
  assign bus.binary_out = out_idx_p1;
  assign bus.out_err    = out_err_p1;

  assign accept   = bus.in_valid && bus.in_ready;
  assign transfer = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          load_out  = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (transfer && accept) begin
          load_out = 1'b1;
        end else if (transfer) begin
          state_nxt = EMPTY;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (transfer) begin
          skid_to_out = 1'b1;
          state_nxt   = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // ---- stage p1: output register and skid entry ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_idx_p1 <= '0;
      out_err_p1 <= 1'b0;
    end else if (load_out) begin
      out_idx_p1 <= enc_idx_p0;
      out_err_p1 <= enc_err_p0;
    end else if (skid_to_out) begin
      out_idx_p1 <= skid_idx_p1;
      out_err_p1 <= skid_err_p1;
    end
  end

  // Skid contents are only meaningful in FULL, which rst leaves, so the
  // data itself needs no reset.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_idx_p1 <= enc_idx_p0;
      skid_err_p1 <= enc_err_p0;
    end
  end

`ifdef ONEHOT_ENC_ERR_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)                      err_count <= '0;
    else if (accept && enc_err_p0) err_count <= sat_inc(err_count);
  end
`endif

endmodule

// File: tb/tb_onehot_encoder_reg.sv
module tb_onehot_encoder_reg;
  localparam int IN_W  = 4;
  localparam int OUT_W = 2;
`ifdef ONEHOT_ENC_ERR_COUNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 8;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [OUT_W-1:0] idx;
    logic             err;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  onehot_encoder_reg_if #(.IN_W(IN_W)) bus ();
`ifdef ONEHOT_ENC_ERR_COUNT_EN
  logic [CNT_W-1:0] err_count;
`endif

  onehot_encoder_reg #(.IN_W(IN_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave)
`ifdef ONEHOT_ENC_ERR_COUNT_EN
    ,
    .err_count (err_count)
`endif
  );

  // Reference: words held by the block, oldest first (at most 2).
  item_t q[$];
  int    model_errs = 0;
  int    total = 0;
  int    bad   = 0;

  function automatic item_t ref_encode(input logic [IN_W-1:0] w);
    item_t r;
    // floor(log2(w)) is the position of the top set bit.
    r.idx = (w == '0) ? '0 : OUT_W'($clog2(int'(w) + 1) - 1);
    r.err = ($countones(w) != 1);
    return r;
  endfunction

  // Advance one clock, updating the reference from the inputs applied
  // before the edge, then settle 1 time unit past the edge.
  task automatic tick();
    logic  acc, xfer;
    item_t it;
    acc  = bus.in_valid && !rst && (q.size() < 2);
    xfer = (q.size() > 0) && bus.out_ready;
    it   = ref_encode(bus.in);
    @(posedge clk);
    if (rst) begin
      q.delete();
      model_errs = 0;
    end else begin
      if (xfer) void'(q.pop_front());
      if (acc) begin
        q.push_back(it);
        if (it.err && model_errs < CNT_MAX) model_errs++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.binary_out !== '0) begin bad++; $display("FAIL reset_binary_out got=%0d want=0", bus.binary_out); end
    total++; if (bus.out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err got=%b want=0", bus.out_err); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_high got=%b want=0", bus.in_ready); end
`ifdef ONEHOT_ENC_ERR_COUNT_EN
    total++; if (err_count !== '0) begin bad++; $display("FAIL reset_err_count got=%0d want=0", err_count); end
`endif
    rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_low got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_stream();
    bus.out_ready = 1'b1;
    for (int k = 0; k < IN_W; k++) begin
      bus.in = IN_W'(1) << k;
      bus.in_valid = 1'b1;
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.binary_out !== OUT_W'(k) || bus.out_err !== 1'b0)
        begin bad++; $display("FAIL stream_%0d got=v%b/%0d/e%b want=v1/%0d/e0", k, bus.out_valid, bus.binary_out, bus.out_err, k); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready_%0d got=%b want=1", k, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_errors();
    bus.out_ready = 1'b1;
    bus.in = 4'b0000;
    bus.in_valid = 1'b1;
    tick();
    total++; if (bus.binary_out !== 2'd0 || bus.out_err !== 1'b1)
      begin bad++; $display("FAIL err_zero got=%0d/e%b want=0/e1", bus.binary_out, bus.out_err); end
    bus.in = 4'b1010;
    tick();
    total++; if (bus.binary_out !== 2'd3 || bus.out_err !== 1'b1)
      begin bad++; $display("FAIL err_multi got=%0d/e%b want=3/e1", bus.binary_out, bus.out_err); end
    bus.in_valid = 1'b0;
    tick();
`ifdef ONEHOT_ENC_ERR_COUNT_EN
    total++; if (err_count !== CNT_W'(2)) begin bad++; $display("FAIL err_count_two got=%0d want=2", err_count); end
`endif
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.in = 4'b0010;
    bus.in_valid = 1'b1;
    tick();
    total++; if (bus.in_ready !== 1'b1 || bus.binary_out !== 2'd1)
      begin bad++; $display("FAIL bp_first got=r%b/%0d want=r1/1", bus.in_ready, bus.binary_out); end
    bus.in = 4'b0100;
    tick();
    total++; if (bus.in_ready !== 1'b0 || bus.binary_out !== 2'd1 || bus.out_valid !== 1'b1)
      begin bad++; $display("FAIL bp_full got=r%b/%0d/v%b want=r0/1/v1", bus.in_ready, bus.binary_out, bus.out_valid); end
    bus.in = 4'b1000;  // offered while full: must not be taken
    tick();
    total++; if (bus.in_ready !== 1'b0 || bus.binary_out !== 2'd1)
      begin bad++; $display("FAIL bp_hold got=r%b/%0d want=r0/1", bus.in_ready, bus.binary_out); end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    total++; if (bus.binary_out !== 2'd2 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1)
      begin bad++; $display("FAIL bp_release got=%0d/v%b/r%b want=2/v1/r1", bus.binary_out, bus.out_valid, bus.in_ready); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_reset_full();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in = 4'b1000;
    tick();
    bus.in = 4'b0000;
    tick();
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rf_full got=%b want=0", bus.in_ready); end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.binary_out !== '0)
      begin bad++; $display("FAIL rf_cleared got=v%b/%0d want=v0/0", bus.out_valid, bus.binary_out); end
`ifdef ONEHOT_ENC_ERR_COUNT_EN
    total++; if (err_count !== '0) begin bad++; $display("FAIL rf_err_count got=%0d want=0", err_count); end
`endif
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rf_stale_%0d got=%b want=0", i, bus.out_valid); end
    end
  endtask

`ifdef ONEHOT_ENC_ERR_COUNT_EN
  task automatic test_saturate();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in = (i % 2 == 0) ? 4'b0000 : 4'b0110;
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    total++; if (err_count !== CNT_W'(CNT_MAX) || model_errs != CNT_MAX)
      begin bad++; $display("FAIL saturate got=%0d want=%0d", err_count, CNT_MAX); end
  endtask
`endif

  task automatic test_random();
    int delivered = 0;
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if (!bus.in_valid)              bus.in = 'x;
      else if ($urandom_range(0, 1))  bus.in = IN_W'(1) << $urandom_range(0, IN_W - 1);
      else                            bus.in = IN_W'($urandom);
      if ((q.size() > 0) && bus.out_ready) delivered++;
      tick();
      total++; if (bus.out_valid !== (q.size() > 0))
        begin bad++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, bus.out_valid, q.size() > 0); end
      total++; if (bus.in_ready !== (q.size() < 2))
        begin bad++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, bus.in_ready, q.size() < 2); end
      if (q.size() > 0) begin
        total++; if (bus.binary_out !== q[0].idx || bus.out_err !== q[0].err)
          begin bad++; $display("FAIL rnd_data c=%0d got=%0d/e%b want=%0d/e%b", c, bus.binary_out, bus.out_err, q[0].idx, q[0].err); end
      end
`ifdef ONEHOT_ENC_ERR_COUNT_EN
      total++; if (err_count !== CNT_W'(model_errs))
        begin bad++; $display("FAIL rnd_err_count c=%0d got=%0d want=%0d", c, err_count, model_errs); end
`endif
    end
    total++; if (delivered < 100) begin bad++; $display("FAIL rnd_throughput got=%0d want>=100", delivered); end
  endtask

  initial begin
    bus.in = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_errors();
    test_backpressure();
    test_reset_full();
`ifdef ONEHOT_ENC_ERR_COUNT_EN
    test_saturate();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
